// File: rtl/audio_gain_path.sv
// Per-channel ramped gain with mute, saturation and peak/clip statistics.
// A single multiplier is time-shared across the channels of each frame.
module audio_gain_path #(
  parameter int BITSIZE  = 24,
  parameter int CHANNELS = 2,
  parameter int GAINBITS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [CHANNELS*BITSIZE-1:0]  in_data,
  input  logic [CHANNELS*GAINBITS-1:0] gain,
  input  logic [CHANNELS-1:0]          mute,
  input  logic                         bypass,
  input  logic                         stat_clr,
  output logic                         out_valid,
  output logic [CHANNELS*BITSIZE-1:0]  out_data,
  output logic [CHANNELS*BITSIZE-1:0]  peak,
  output logic [CHANNELS-1:0]          clip,
  output logic                         overrun,
  output logic                         busy
);

  localparam int PW = BITSIZE + GAINBITS + 1;
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic signed [PW-1:0] SAT_MAX = {{(GAINBITS+2){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(GAINBITS+2){1'b1}}, {(BITSIZE-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  function automatic logic sat_hit(input logic signed [PW-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [BITSIZE-1:0] saturate(input logic signed [PW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[BITSIZE-1:0];
    if (v < SAT_MIN) return SAT_MIN[BITSIZE-1:0];
    return v[BITSIZE-1:0];
  endfunction

  // The most negative sample maps onto itself, which reads correctly as unsigned.
  function automatic logic [BITSIZE-1:0] magnitude(input logic signed [BITSIZE-1:0] v);
    logic [BITSIZE-1:0] neg;
    neg = -v;
    return v[BITSIZE-1] ? neg : v;
  endfunction

  function automatic logic [GAINBITS-1:0] ramp_step(input logic [GAINBITS-1:0] cur,
                                                    input logic [GAINBITS-1:0] tgt);
    if (cur < tgt) return cur + 1'b1;
    if (cur > tgt) return cur - 1'b1;
    return cur;
  endfunction

  state_t                      state;
  logic [IW-1:0]               idx;
  logic                        byp_p0;
  logic [CHANNELS*BITSIZE-1:0] frame_p0;
  logic [CHANNELS*BITSIZE-1:0] res_p1;
  logic [GAINBITS-1:0]         cur_gain [CHANNELS];

  logic                        vld_p1;
  logic signed [BITSIZE-1:0]   x_p1;
  logic [GAINBITS-1:0]         g_p1;
  logic [GAINBITS-1:0]         tgt_p1;
  logic signed [PW-1:0]        prod_p1;
  logic signed [PW-1:0]        scaled_p1;
  logic signed [BITSIZE-1:0]   y_p1;
  logic                        clip_p1;
  logic [BITSIZE-1:0]          mag_p1;
  logic [CHANNELS*BITSIZE-1:0] frame_out_p1;

  // Stage p1: one channel per MAC cycle through the shared multiplier
  always_comb begin
    vld_p1       = (state == MAC);
    x_p1         = '0;
    g_p1         = '0;
    tgt_p1       = '0;
    frame_out_p1 = res_p1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == IW'(k)) begin
        x_p1   = frame_p0[k*BITSIZE +: BITSIZE];
        g_p1   = cur_gain[k];
        tgt_p1 = mute[k] ? '0 : gain[k*GAINBITS +: GAINBITS];
      end
    end
    prod_p1   = PW'(x_p1) * PW'($signed({1'b0, g_p1}));
    scaled_p1 = prod_p1 >>> (GAINBITS - 1);
    if (byp_p0) begin
      y_p1    = x_p1;
      clip_p1 = 1'b0;
    end else begin
      y_p1    = saturate(scaled_p1);
      clip_p1 = sat_hit(scaled_p1);
    end
    mag_p1 = magnitude(y_p1);
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == IW'(k)) frame_out_p1[k*BITSIZE +: BITSIZE] = y_p1;
    end
  end

  // Stage p0: frame capture; data registers carry no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) frame_p0 <= in_data;
    if (vld_p1) res_p1 <= frame_out_p1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      byp_p0    <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      peak      <= '0;
      clip      <= '0;
      overrun   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) cur_gain[k] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            byp_p0 <= bypass;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= MAC;
          end
        end
        MAC: begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (idx == IW'(k)) cur_gain[k] <= ramp_step(g_p1, tgt_p1);
          end
          if (idx == IW'(CHANNELS - 1)) begin
            out_valid <= 1'b1;
            out_data  <= frame_out_p1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (in_valid && busy) overrun <= 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
        if (vld_p1 && idx == IW'(k)) begin
          if (mag_p1 > peak[k*BITSIZE +: BITSIZE]) peak[k*BITSIZE +: BITSIZE] <= mag_p1;
          if (clip_p1) clip[k] <= 1'b1;
        end
      end
      // A clear landing on the same edge as an update discards that update.
      if (stat_clr) begin
        peak    <= '0;
        clip    <= '0;
        overrun <= 1'b0;
      end
    end
  end

endmodule
